// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI responder running entirely in the system clock domain. sclk, cs and
// mosi are oversampled through synchronizer chains and edges are detected
// by comparing the last synchronized stage with a one-clock delayed copy.
// Nothing here is clocked by sclk.
//
// Byte-wide user side:
//   transmit: one-byte holding register written through a valid/ready
//             handshake. The byte is copied into the shift register when a
//             transfer starts or at each byte boundary. An empty holding
//             register sends 8'h00 (underrun).
//   receive : rx_data holds the last complete byte. rx_valid pulses for one
//             clk when rx_data updates.
//
// Handshake: tx_data is written on every rising clk edge where
//   tx_valid && tx_ready. tx_ready is high exactly when the holding register
//   is empty. tx_ready does not depend on tx_valid. The source may raise
//   tx_valid at any time and must hold tx_data stable while tx_valid is high.
//
// Parameters:
//   CPOL        sclk idle level; must match the master.
//   CPHA        0: sample on leading edge, shift on trailing edge.
//               1: shift on leading edge, sample on trailing edge.
//   SYNC_STAGES synchronizer depth on sclk, cs and mosi (>= 2).
//
// Ports:
//   clk        system clock; all logic on the rising edge.
//   rst        asynchronous active-low reset.
//   sclk       SPI clock from the master (f_sclk <= f_clk/8).
//   cs         chip select, active low.
//   mosi       master-out data.
//   miso       slave-out data.
//   miso_oe    miso output enable, high only while selected.
//   tx_data    next byte to transmit.
//   tx_valid   tx_data is valid.
//   tx_ready   holding register empty.
//   rx_data    last complete received byte.
//   rx_valid   one-clk pulse when rx_data updates.
//   busy       high while the synchronized cs is asserted.
//   state_dbg  current FSM state (0 = IDLE, 1 = ACTIVE).
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       state_dbg
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;

    // The cs chain resets to the asserted level. A cs still held low across
    // reset release then produces no falling edge. The next transfer only
    // starts after the master deselects and selects again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= CPOL;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;
    logic cs_rise;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign lead_edge   = (sclk_d == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_d != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [7:0] hold_data;
    logic       hold_full;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_cnt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle control strobes
    // ------------------------------------------------------------------
    logic start;      // transfer begins: load shift register
    logic do_sample;  // capture one mosi bit
    logic do_shift;   // advance miso
    logic byte_done;  // this sample completes a byte
    logic reload;     // byte boundary with cs still low
    logic stop;       // cs released: back to idle

    always_comb begin
        state_next = state;
        start      = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        byte_done  = 1'b0;
        reload     = 1'b0;
        stop       = 1'b0;
        miso_oe    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                miso_oe   = 1'b1;
                busy      = 1'b1;
                do_sample = sample_edge;
                do_shift  = shift_edge;
                byte_done = sample_edge && (bit_cnt == 3'd7);
                // A byte completing together with cs rising is still
                // delivered. Leave the holding register untouched so an
                // unsent byte waits for the next transfer.
                reload    = byte_done && !cs_rise;
                if (cs_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign state_dbg = (state == ACTIVE);

    // ------------------------------------------------------------------
    // Transmit holding register
    // ------------------------------------------------------------------
    logic       consume;
    logic [7:0] load_byte;

    assign consume   = start | reload;
    assign load_byte = hold_full ? hold_data : 8'h00;
    assign tx_ready  = ~hold_full;

    // Consume and write cannot both hit a full register. A write requires
    // it empty. So when a write lands in a consume cycle, the register was
    // empty (8'h00 went out) and the new byte simply fills it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
        end else begin
            if (consume) begin
                hold_full <= 1'b0;
            end
            if (tx_valid && tx_ready) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shift registers, bit counter, miso and receive output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            bit_cnt  <= 3'd0;
            miso     <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (start) begin
                tx_shift <= load_byte;
                bit_cnt  <= 3'd0;
                // In CPHA=0 the master samples on the first edge, so bit 7
                // must already be on miso when cs falls.
                if (CPHA == 1'b0) begin
                    miso <= load_byte[7];
                end
            end

            if (do_sample) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (byte_done) begin
                    rx_data  <= {rx_shift[6:0], mosi_s};
                    rx_valid <= 1'b1;
                end
            end

            if (reload) begin
                tx_shift <= load_byte;
            end

            if (do_shift) begin
                if (CPHA == 1'b0) begin
                    // The shift register was reloaded at the 8th sample.
                    // The trailing edge after it presents the new bit 7
                    // instead of shifting past it.
                    if (bit_cnt == 3'd0) begin
                        miso <= tx_shift[7];
                    end else begin
                        miso     <= tx_shift[6];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end else begin
                    miso     <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end

            if (stop) begin
                bit_cnt <= 3'd0;
                miso    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Two responders share sclk and mosi, each with its own chip select:
//   dut0: CPOL=0, CPHA=0 (mode 0)
//   dut1: CPOL=0, CPHA=1 (mode 1)
// Received bytes and bytes read from miso are checked against expected
// queues filled by the tests as stimulus is driven.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int HALF = 80;  // sclk half period in ns (clk period is 10 ns)

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs0 = 1'b1;
    logic       cs1 = 1'b1;

    logic       miso0, miso_oe0, tx_ready0, rx_valid0, busy0, dbg0;
    logic [7:0] rx_data0;
    logic [7:0] tx_data0 = 8'h00;
    logic       tx_valid0 = 1'b0;

    logic       miso1, miso_oe1, tx_ready1, rx_valid1, busy1, dbg1;
    logic [7:0] rx_data1;
    logic [7:0] tx_data1 = 8'h00;
    logic       tx_valid1 = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] miso_exp_q[$];
    logic [7:0] mon_got;
    logic [7:0] mon_exp;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    spi_slave #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs0), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
        .state_dbg(dbg0)
    );

    spi_slave #(.CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs1), .mosi(mosi),
        .miso(miso1), .miso_oe(miso_oe1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
        .state_dbg(dbg1)
    );

    // ---------------- receive scoreboard ----------------
    always @(negedge clk) begin
        if (rst && (rx_valid0 || rx_valid1)) begin
            mon_got = rx_valid0 ? rx_data0 : rx_data1;
            checks++;
            if (rx_exp_q.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected got=%h required=none", mon_got);
            end else begin
                mon_exp = rx_exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL rx_byte got=%h required=%h", mon_got, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tx_write(input int sel, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (((sel == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            failures++;
            $display("FAIL tx_write_timeout tx_ready=0 required=1");
        end else begin
            if (sel == 0) begin
                tx_data0  = d;
                tx_valid0 = 1'b1;
            end else begin
                tx_data1  = d;
                tx_valid1 = 1'b1;
            end
            @(negedge clk);
            tx_valid0 = 1'b0;
            tx_valid1 = 1'b0;
        end
    endtask

    task automatic cs_low(input int sel);
        @(negedge clk);
        if (sel == 0) cs0 = 1'b0;
        else          cs1 = 1'b0;
        #100;
    endtask

    task automatic cs_high(input int sel);
        #HALF;
        if (sel == 0) cs0 = 1'b1;
        else          cs1 = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // sel 0 drives mode 0 timing, sel 1 drives mode 1 timing. A full byte
    // read from miso is compared against the next expected miso byte.
    task automatic spi_byte(input int sel, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rd);
        logic [7:0] e;
        rd = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (sel == 0) begin
                mosi = tx[7-i];
                #HALF;
                rd   = {rd[6:0], miso0};
                sclk = 1'b1;
                #HALF;
                sclk = 1'b0;
            end else begin
                sclk = 1'b1;
                mosi = tx[7-i];
                #HALF;
                rd   = {rd[6:0], miso1};
                sclk = 1'b0;
                #HALF;
            end
        end
        if (nbits == 8) begin
            checks++;
            if (miso_exp_q.size() == 0) begin
                failures++;
                $display("FAIL miso_unexpected got=%h required=none", rd);
            end else begin
                e = miso_exp_q.pop_front();
                if (rd !== e) begin
                    failures++;
                    $display("FAIL miso_byte got=%h required=%h", rd, e);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({miso0, miso_oe0, tx_ready0, rx_valid0, busy0, dbg0} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_ctl0 got=%b required=001000",
                     {miso0, miso_oe0, tx_ready0, rx_valid0, busy0, dbg0});
        end
        checks++;
        if (rx_data0 !== 8'h00) begin
            failures++;
            $display("FAIL reset_rx0 got=%h required=00", rx_data0);
        end
        checks++;
        if ({miso1, miso_oe1, tx_ready1, rx_valid1, busy1, dbg1} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_ctl1 got=%b required=001000",
                     {miso1, miso_oe1, tx_ready1, rx_valid1, busy1, dbg1});
        end
    endtask

    task automatic test_mode0();
        logic [7:0] rd;
        tx_write(0, 8'hA5);
        checks++;
        if (tx_ready0 !== 1'b0) begin
            failures++;
            $display("FAIL m0_tx_ready_after_write got=%b required=0", tx_ready0);
        end
        rx_exp_q.push_back(8'h3C);
        miso_exp_q.push_back(8'hA5);
        cs_low(0);
        checks++;
        if ({busy0, miso_oe0, tx_ready0} !== 3'b111) begin
            failures++;
            $display("FAIL m0_selected busy,oe,ready got=%b required=111",
                     {busy0, miso_oe0, tx_ready0});
        end
        spi_byte(0, 8'h3C, 8, rd);
        cs_high(0);
        checks++;
        if ({busy0, miso_oe0} !== 2'b00) begin
            failures++;
            $display("FAIL m0_deselected busy,oe got=%b required=00", {busy0, miso_oe0});
        end
        checks++;
        if (rx_data0 !== 8'h3C || rx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL m0_rx rx_data=%h pending=%0d required=3c pending=0",
                     rx_data0, rx_exp_q.size());
        end
    endtask

    task automatic test_mode1();
        logic [7:0] rd;
        checks++;
        if (miso_oe1 !== 1'b0) begin
            failures++;
            $display("FAIL m1_oe_before got=%b required=0", miso_oe1);
        end
        tx_write(1, 8'hC3);
        rx_exp_q.push_back(8'h81);
        miso_exp_q.push_back(8'hC3);
        cs_low(1);
        checks++;
        if (miso_oe1 !== 1'b1) begin
            failures++;
            $display("FAIL m1_oe_during got=%b required=1", miso_oe1);
        end
        spi_byte(1, 8'h81, 8, rd);
        cs_high(1);
        checks++;
        if (miso_oe1 !== 1'b0) begin
            failures++;
            $display("FAIL m1_oe_after got=%b required=0", miso_oe1);
        end
        checks++;
        if (rx_data1 !== 8'h81 || rx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL m1_rx rx_data=%h pending=%0d required=81 pending=0",
                     rx_data1, rx_exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        tx_write(0, 8'h11);
        rx_exp_q.push_back(8'h01);
        rx_exp_q.push_back(8'h02);
        rx_exp_q.push_back(8'h03);
        miso_exp_q.push_back(8'h11);
        miso_exp_q.push_back(8'h22);
        miso_exp_q.push_back(8'h33);
        cs_low(0);
        tx_write(0, 8'h22);
        spi_byte(0, 8'h01, 8, rd);
        tx_write(0, 8'h33);
        spi_byte(0, 8'h02, 8, rd);
        spi_byte(0, 8'h03, 8, rd);
        cs_high(0);
        checks++;
        if (rx_data0 !== 8'h03 || rx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_rx rx_data=%h pending=%0d required=03 pending=0",
                     rx_data0, rx_exp_q.size());
        end
    endtask

    task automatic test_underrun();
        logic [7:0] rd;
        checks++;
        if (tx_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL underrun_empty tx_ready=%b required=1", tx_ready0);
        end
        rx_exp_q.push_back(8'h96);
        miso_exp_q.push_back(8'h00);
        cs_low(0);
        spi_byte(0, 8'h96, 8, rd);
        cs_high(0);
        checks++;
        if (rx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL underrun_rx_missing pending=%0d required=0", rx_exp_q.size());
        end
    endtask

    task automatic test_abort();
        logic [7:0] rd;
        rx_exp_q.push_back(8'h3C);
        miso_exp_q.push_back(8'h00);
        cs_low(0);
        spi_byte(0, 8'h3C, 8, rd);
        cs_high(0);
        // partial byte with a holding byte written after cs fell
        cs_low(0);
        tx_write(0, 8'h77);
        spi_byte(0, 8'hAA, 5, rd);
        cs_high(0);
        checks++;
        if (rx_data0 !== 8'h3C || rx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_rx_kept rx_data=%h pending=%0d required=3c pending=0",
                     rx_data0, rx_exp_q.size());
        end
        checks++;
        if ({tx_ready0, busy0, miso_oe0} !== 3'b000) begin
            failures++;
            $display("FAIL abort_state ready,busy,oe got=%b required=000",
                     {tx_ready0, busy0, miso_oe0});
        end
        rx_exp_q.push_back(8'hF0);
        miso_exp_q.push_back(8'h77);
        cs_low(0);
        spi_byte(0, 8'hF0, 8, rd);
        cs_high(0);
        checks++;
        if (rx_data0 !== 8'hF0 || rx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_next_rx rx_data=%h pending=%0d required=f0 pending=0",
                     rx_data0, rx_exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        tx_write(0, 8'h99);
        cs_low(0);
        spi_byte(0, 8'hE7, 3, rd);
        rst = 1'b0;
        #1;
        checks++;
        if ({miso0, miso_oe0, tx_ready0, rx_valid0, busy0, dbg0} !== 6'b001000) begin
            failures++;
            $display("FAIL rstmid_ctl got=%b required=001000",
                     {miso0, miso_oe0, tx_ready0, rx_valid0, busy0, dbg0});
        end
        checks++;
        if (rx_data0 !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_rx got=%h required=00", rx_data0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_restart busy=%b required=0", busy0);
        end
        cs_high(0);
        rx_exp_q.push_back(8'h5A);
        miso_exp_q.push_back(8'h00);
        cs_low(0);
        spi_byte(0, 8'h5A, 8, rd);
        cs_high(0);
        checks++;
        if (rx_data0 !== 8'h5A || rx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_next_rx rx_data=%h pending=%0d required=5a pending=0",
                     rx_data0, rx_exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] rd;
        logic [7:0] t;
        logic [7:0] r;
        for (int k = 0; k < 4; k++) begin
            t = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            tx_write(0, t);
            rx_exp_q.push_back(r);
            miso_exp_q.push_back(t);
            cs_low(0);
            spi_byte(0, r, 8, rd);
            cs_high(0);
        end
        checks++;
        if (rx_exp_q.size() != 0 || miso_exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_pending rx=%0d miso=%0d required=0", rx_exp_q.size(),
                     miso_exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_random();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        checks++;
        failures++;
        $display("FAIL watchdog time_limit reached required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI peripheral (responder) end of the team's SPI link. It accepts sclk/cs/mosi from an external or on-chip SPI master, shifts in a byte MSB first, and shifts out a byte on miso. It runs entirely in the system clock domain: the SPI inputs are oversampled through synchronizers, so no logic is clocked by sclk. It sits between the pin-level SPI bus and a byte-wide user interface with a ready/valid handshake on the transmit side and a pulsed strobe on the receive side.

Parameters:
CPOL, 1'b0, sclk idle level; must match the master.
CPHA, 1'b0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
SYNC_STAGES, 2, flip-flop stages on sclk, cs and mosi (minimum 2).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
sclk  in  1  SPI clock from the master.
cs  in  1  chip select, active low.
mosi  in  1  master-out data.
miso  out  1  slave-out data.
miso_oe  out  1  miso output enable (high only while selected).
tx_data  in  8  next byte to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  holding register empty; a tx_valid&tx_ready cycle writes tx_data.
rx_data  out  8  last complete received byte; held until the next byte completes.
rx_valid  out  1  one-clk pulse when rx_data updates.
busy  out  1  high while cs is asserted (synchronized).

Behaviour:
- Reset (rst=0, asynchronous): miso=0, miso_oe=0, tx_ready=1, rx_data=8'h00, rx_valid=0, busy=0, bit counter=0, holding register empty, state=IDLE.
- Synchronization: sclk, cs and mosi each pass through SYNC_STAGES flip-flops. Edges are detected by comparing the last synchronized stage against a delayed copy.
  - Leading edge: sclk changes from CPOL to ~CPOL. Trailing edge: the reverse.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
  - Requirement: f_sclk ≤ f_clk/8.
- Transmit holding register: one byte.
  - A cycle with tx_valid&tx_ready loads it and clears tx_ready.
  - Moving the byte into the shift register sets tx_ready on the next clk.
- State IDLE:
  - miso_oe=0, bit counter=0.
  - On the synchronized cs falling edge, go to ACTIVE and set busy=1.
  - Load the shift register from the holding register if it is full; otherwise load 8'h00 (underrun).
  - If CPHA=0, drive miso=shift[7] in the same cycle.
- State ACTIVE:
  - miso_oe=1.
  - On each sample edge: rx_shift <= {rx_shift[6:0], mosi_sync}; bit counter increments modulo 8.
  - On the sample edge that takes the counter 7→0: rx_data <= the completed byte and rx_valid pulses high for exactly 1 clk. This occurs SYNC_STAGES+1 clk after the 8th sample edge at the pin.
  - On each shift edge:
    - CPHA=0: shift the tx register left and drive the new shift[7].
    - CPHA=1: drive shift[7], then shift. The first leading edge after cs falls drives bit 7.
  - Byte boundary while cs stays low: reload the tx shift register from the holding register (or 8'h00 if empty).
    - CPHA=0: at the 8th sample edge, with miso presented at the following trailing edge.
    - CPHA=1: before the next leading edge.
  - Bytes are back to back with no gap.
- cs rising in ACTIVE (any bit count):
  - Return to IDLE; miso_oe=0 and busy=0 on the same clk.
  - A partial byte is discarded: no rx_valid, rx_data unchanged, bit counter reset to 0.
  - If the holding register was loaded but never shifted, it stays loaded for the next transaction.
- Simultaneous events:
  - A tx_valid write in the same clk the holding register is consumed is accepted only if tx_ready was high in that cycle.
  - A cs rise coinciding with the 8th sample edge completes the byte (rx_valid pulses), then the block goes to IDLE.
- sclk edges while cs is high are ignored.
- Asynchronous reset mid-transfer: all state returns to reset values immediately. The next transfer starts cleanly only on a new cs falling edge.

Test Plan:
- Mode 0, tx_data=8'hA5 written before cs falls; master sends 8'h3C → miso shows 1,0,1,0,0,1,0,1 on the rising edges; rx_data=8'h3C with a single 1-clk rx_valid; tx_ready returns to 1 after the load.
- Mode 1 (CPHA=1), tx 8'hC3, master sends 8'h81 → master reads 8'hC3, rx_data=8'h81; miso_oe is low before cs falls and after cs rises.
- Back-to-back: 3 bytes 8'h01,8'h02,8'h03 under one cs, tx refilled after each tx_ready → three rx_valid pulses; miso carries 8'h11,8'h22,8'h33 with no dropped bit.
- Underrun: no tx write before cs falls → miso outputs 8'h00; rx still captured correctly.
- Abort: cs rises after 5 bits → no rx_valid, rx_data keeps its previous value 8'h3C; the next full byte 8'hF0 is received correctly.
- Reset mid-byte: rst low after 3 bits → all outputs at reset values; the following transaction 8'h5A is received intact.
